// File: rtl/quad_encoder_io_if.sv
// Processor IO-space load/store bus as seen by one memory-mapped peripheral.
// Loads are combinational; stores take effect on the clock edge ending the store cycle.
interface quad_encoder_io_if;
   logic        IOinsn;
   logic        wren;
   logic [31:0] memAddr;
   logic [31:0] dataIn;
   logic [31:0] dataOut;

   modport master (output IOinsn, output wren, output memAddr, output dataIn, input dataOut);
   modport slave  (input IOinsn, input wren, input memAddr, input dataIn, output dataOut);
endinterface

// File: rtl/quad_encoder_io.sv
// Quadrature encoder reader: sync + debounce of A/B/limit, x4 decode to a 32-bit position, windowed velocity.
// Pin-to-position latency 3 + DEBOUNCE_CYCLES cycles; never stalls the bus, loads are combinational.
module quad_encoder_io #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WINDOW_CYCLES   = 100000
) (
   input  logic              clk,
   input  logic              reset,
   quad_encoder_io_if.slave  bus,
   input  logic [2:0]        JB
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int WW = $clog2(WINDOW_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
   localparam logic [31:0]   ID_VALUE = 32'h0E4C_0001;

   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    filt_q, filt_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic [1:0]    prev_ba_q;
   logic          prev_lim_q;
   logic [1:0]    vld_q;
   logic          primed_q, primed_d;
   logic          dir_q, dir_d;
   logic          err_q, err_d;
   logic          lim_q, lim_d;
   logic [31:0]   pos_q, pos_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   vel_q, vel_d;
   logic [WW-1:0] win_q, win_d;

   logic          changed, illegal, up, step_up, step_dn;
   logic [31:0]   step_val;
   logic          store, st_pos, st_stat;
   logic          unused_addr;

   assign unused_addr = ^{bus.memAddr[31:14], bus.memAddr[12:4], bus.memAddr[1:0]};

   // A pin's filtered value flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_LAST) filt_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_comb begin
      changed = filt_q[1:0] != prev_ba_q;
      illegal = (filt_q[1:0] ^ prev_ba_q) == 2'b11;
      up = (prev_ba_q == 2'b00 && filt_q[1:0] == 2'b01) ||
           (prev_ba_q == 2'b01 && filt_q[1:0] == 2'b11) ||
           (prev_ba_q == 2'b11 && filt_q[1:0] == 2'b10) ||
           (prev_ba_q == 2'b10 && filt_q[1:0] == 2'b00);
      step_up = primed_q && changed && !illegal && up;
      step_dn = primed_q && changed && !illegal && !up;
      step_val = step_up ? 32'd1 : (step_dn ? 32'hFFFF_FFFF : 32'd0);
   end

   always_comb begin
      store   = bus.IOinsn && bus.wren && bus.memAddr[13];
      st_pos  = store && (bus.memAddr[3:2] == 2'd0);
      st_stat = store && (bus.memAddr[3:2] == 2'd1);

      // Pins already at the reset value never produce a filter update, so prime once the sync chain agrees.
      primed_d = primed_q || changed || (vld_q[1] && (sync2_q[1:0] == filt_q[1:0]));

      pos_d = st_pos ? bus.dataIn : pos_q + step_val;
      dir_d = step_up ? 1'b1 : (step_dn ? 1'b0 : dir_q);
      err_d = (err_q && !(st_stat && bus.dataIn[1])) || (primed_q && changed && illegal);
      lim_d = (lim_q && !(st_stat && bus.dataIn[2])) || (primed_q && filt_q[2] && !prev_lim_q);

      if (win_q == WIN_LAST) begin
         win_d = '0;
         vel_d = acc_q + step_val;
         acc_d = '0;
      end else begin
         win_d = win_q + WW'(1);
         vel_d = vel_q;
         acc_d = acc_q + step_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         filt_q     <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
         prev_ba_q  <= '0;
         prev_lim_q <= 1'b0;
         vld_q      <= '0;
         primed_q   <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         lim_q      <= 1'b0;
         pos_q      <= '0;
         acc_q      <= '0;
         vel_q      <= '0;
         win_q      <= '0;
      end else begin
         sync1_q    <= JB;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
         prev_ba_q  <= filt_q[1:0];
         prev_lim_q <= filt_q[2];
         vld_q      <= {vld_q[0], 1'b1};
         primed_q   <= primed_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         lim_q      <= lim_d;
         pos_q      <= pos_d;
         acc_q      <= acc_d;
         vel_q      <= vel_d;
         win_q      <= win_d;
      end
   end

   always_comb begin
      bus.dataOut = 32'd0;
      if (bus.memAddr[13]) begin
         case (bus.memAddr[3:2])
            2'd0:    bus.dataOut = pos_q;
            2'd1:    bus.dataOut = {25'd0, primed_q, filt_q[1:0], filt_q[2], lim_q, err_q, dir_q};
            2'd2:    bus.dataOut = vel_q;
            default: bus.dataOut = ID_VALUE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_encoder_io.sv
// Directed bench for quad_encoder_io with DEBOUNCE_CYCLES=4, WINDOW_CYCLES=50.
module tb_quad_encoder_io;

   localparam logic [31:0] A_POS  = 32'h0000_2000;
   localparam logic [31:0] A_STAT = 32'h0000_2004;
   localparam logic [31:0] A_VEL  = 32'h0000_2008;
   localparam logic [31:0] A_ID   = 32'h0000_200C;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] JB;
   int         checks = 0;
   int         failures = 0;
   logic [31:0] d;
   logic [2:0] up_seq [4];
   logic [2:0] dn_seq [5];

   quad_encoder_io_if bus ();

   quad_encoder_io #(.DEBOUNCE_CYCLES(4), .WINDOW_CYCLES(50)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .JB    (JB)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      bus.memAddr = a;
      #1;
      v = bus.dataOut;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      bus.IOinsn  = 1'b1;
      bus.wren    = 1'b1;
      bus.memAddr = a;
      bus.dataIn  = v;
      @(negedge clk);
      bus.IOinsn  = 1'b0;
      bus.wren    = 1'b0;
      bus.dataIn  = 32'd0;
   endtask

   task automatic do_reset(input logic [2:0] pins);
      JB = pins;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      JB = 3'b000;
      reset = 1'b1;
      tick(3);
      rd(A_POS, d);  checks++; if (d !== 32'd0)        begin failures++; $display("FAIL reset_pos got=%h exp=%h", d, 32'd0); end
      rd(A_STAT, d); checks++; if (d !== 32'd0)        begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'd0); end
      rd(A_VEL, d);  checks++; if (d !== 32'd0)        begin failures++; $display("FAIL reset_vel got=%h exp=%h", d, 32'd0); end
      rd(A_ID, d);   checks++; if (d !== 32'h0E4C0001) begin failures++; $display("FAIL reset_id got=%h exp=%h", d, 32'h0E4C0001); end
      reset = 1'b0;
   endtask

   task automatic test_up_count();
      tick(10);
      rd(A_STAT, d); checks++; if (d !== 32'h40) begin failures++; $display("FAIL up_primed got=%h exp=%h", d, 32'h40); end
      JB = up_seq[0];
      tick(6);
      rd(A_POS, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL up_latency_early got=%h exp=%h", d, 32'd0); end
      tick(1);
      rd(A_POS, d); checks++; if (d !== 32'd1) begin failures++; $display("FAIL up_latency_7 got=%h exp=%h", d, 32'd1); end
      tick(13);
      for (int i = 1; i < 8; i++) begin
         JB = up_seq[i % 4];
         tick(20);
      end
      rd(A_POS, d);  checks++; if (d !== 32'd8)  begin failures++; $display("FAIL up_pos got=%h exp=%h", d, 32'd8); end
      rd(A_STAT, d); checks++; if (d !== 32'h41) begin failures++; $display("FAIL up_status got=%h exp=%h", d, 32'h41); end
   endtask

   task automatic test_glitch();
      JB = 3'b001;
      tick(3);
      JB = 3'b000;
      tick(20);
      rd(A_POS, d);  checks++; if (d !== 32'd8)       begin failures++; $display("FAIL glitch3_pos got=%h exp=%h", d, 32'd8); end
      rd(A_STAT, d); checks++; if (d[5:4] !== 2'b00)  begin failures++; $display("FAIL glitch3_ba got=%b exp=%b", d[5:4], 2'b00); end
      JB = 3'b001;
      tick(4);
      JB = 3'b000;
      tick(4);
      rd(A_POS, d);  checks++; if (d !== 32'd9)  begin failures++; $display("FAIL glitch4_up got=%h exp=%h", d, 32'd9); end
      tick(12);
      rd(A_POS, d);  checks++; if (d !== 32'd8)  begin failures++; $display("FAIL glitch4_back got=%h exp=%h", d, 32'd8); end
      rd(A_STAT, d); checks++; if (d !== 32'h40) begin failures++; $display("FAIL glitch4_status got=%h exp=%h", d, 32'h40); end
   endtask

   task automatic test_illegal();
      JB = 3'b011;
      tick(20);
      rd(A_STAT, d); checks++; if (d !== 32'h72) begin failures++; $display("FAIL illegal_err got=%h exp=%h", d, 32'h72); end
      rd(A_POS, d);  checks++; if (d !== 32'd8)  begin failures++; $display("FAIL illegal_pos got=%h exp=%h", d, 32'd8); end
      wr(A_STAT, 32'h2);
      rd(A_STAT, d); checks++; if (d !== 32'h70) begin failures++; $display("FAIL illegal_w1c got=%h exp=%h", d, 32'h70); end
      JB = 3'b000;
      tick(6);
      wr(A_STAT, 32'h2);
      tick(14);
      rd(A_STAT, d); checks++; if (d !== 32'h42) begin failures++; $display("FAIL illegal_set_wins got=%h exp=%h", d, 32'h42); end
      rd(A_POS, d);  checks++; if (d !== 32'd8)  begin failures++; $display("FAIL illegal_pos2 got=%h exp=%h", d, 32'd8); end
      wr(A_STAT, 32'h2);
      rd(A_STAT, d); checks++; if (d !== 32'h40) begin failures++; $display("FAIL illegal_clear2 got=%h exp=%h", d, 32'h40); end
   endtask

   task automatic test_preset_wrap();
      wr(A_POS, 32'h7FFF_FFFF);
      rd(A_POS, d); checks++; if (d !== 32'h7FFF_FFFF) begin failures++; $display("FAIL preset got=%h exp=%h", d, 32'h7FFF_FFFF); end
      JB = 3'b001;
      tick(20);
      rd(A_POS, d); checks++; if (d !== 32'h8000_0000) begin failures++; $display("FAIL wrap got=%h exp=%h", d, 32'h8000_0000); end
      JB = 3'b011;
      tick(6);
      wr(A_POS, 32'h1234_5678);
      tick(13);
      rd(A_POS, d); checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL store_wins got=%h exp=%h", d, 32'h1234_5678); end
   endtask

   task automatic test_velocity();
      do_reset(3'b000);
      tick(3);
      for (int i = 0; i < 5; i++) begin
         JB = dn_seq[i];
         tick(6);
      end
      tick(18);
      rd(A_VEL, d); checks++; if (d !== 32'hFFFF_FFFB) begin failures++; $display("FAIL vel_window got=%h exp=%h", d, 32'hFFFF_FFFB); end
      rd(A_POS, d); checks++; if (d !== 32'hFFFF_FFFB) begin failures++; $display("FAIL vel_pos got=%h exp=%h", d, 32'hFFFF_FFFB); end
      tick(50);
      rd(A_VEL, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL vel_idle got=%h exp=%h", d, 32'd0); end
   endtask

   task automatic test_priming();
      do_reset(3'b011);
      tick(20);
      rd(A_STAT, d); checks++; if (d !== 32'h70) begin failures++; $display("FAIL prime_status got=%h exp=%h", d, 32'h70); end
      rd(A_POS, d);  checks++; if (d !== 32'd0)  begin failures++; $display("FAIL prime_pos got=%h exp=%h", d, 32'd0); end
      JB = 3'b111;
      tick(20);
      rd(A_STAT, d); checks++; if (d !== 32'h7C) begin failures++; $display("FAIL prime_lim got=%h exp=%h", d, 32'h7C); end
      rd(32'h0000_0004, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL unselected got=%h exp=%h", d, 32'd0); end
      rd(A_ID, d);   checks++; if (d !== 32'h0E4C0001) begin failures++; $display("FAIL id got=%h exp=%h", d, 32'h0E4C0001); end
      wr(A_STAT, 32'h4);
      rd(A_STAT, d); checks++; if (d !== 32'h78) begin failures++; $display("FAIL lim_w1c got=%h exp=%h", d, 32'h78); end
   endtask

   initial begin
      up_seq[0] = 3'b001; up_seq[1] = 3'b011; up_seq[2] = 3'b010; up_seq[3] = 3'b000;
      dn_seq[0] = 3'b010; dn_seq[1] = 3'b011; dn_seq[2] = 3'b001; dn_seq[3] = 3'b000; dn_seq[4] = 3'b010;
      reset       = 1'b1;
      JB          = 3'b000;
      bus.IOinsn  = 1'b0;
      bus.wren    = 1'b0;
      bus.memAddr = 32'd0;
      bus.dataIn  = 32'd0;
      @(negedge clk);
      test_reset();
      test_up_count();
      test_glitch();
      test_illegal();
      test_preset_wrap();
      test_velocity();
      test_priming();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
